avalon_tb_sequencer: RTL
========================

Name: avalon_tb_sequencer

Overview:
- Avalon-MM master that drives the testbench control/status register slave from the other end of its 4-bit-address register interface.
- On one `start` pulse it runs a complete measurement:
  - reset the testbench, enable it for a programmed number of cycles, then freeze it;
  - read back data counter, event counter and system version.
- Lets the measurement run in hardware without a host issuing individual register accesses; results are presented on parallel outputs.

Parameters:
- WIDTH, 32, data width of the Avalon bus and of all result/length ports.
- READ_LATENCY, 1, cycles from the read-strobe cycle to the cycle in which `m_readdata` is valid; legal values 1–4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a sequence.
- run_len  input  WIDTH  number of enabled cycles between enable-write and freeze-write; sampled on accepted start.
- busy  output  1  high from accepted start until the cycle before done.
- done  output  1  one-cycle pulse when all three results are captured.
- data_ctr  output  WIDTH  value read from address 2.
- event_ctr  output  WIDTH  value read from address 3.
- sys_version  output  WIDTH  value read from address 4.
- m_address  output  4  Avalon address.
- m_read  output  1  Avalon read strobe.
- m_write  output  1  Avalon write strobe.
- m_writedata  output  WIDTH  Avalon write data.
- m_readdata  input  WIDTH  Avalon read data.

Behaviour:
- Reset (async assert, sync release); all outputs 0:
  - m_read, m_write, m_address, m_writedata;
  - busy, done;
  - data_ctr, event_ctr, sys_version.
  - FSM returns to IDLE. Asserting reset mid-sequence drops strobes immediately; no partial results are kept.
- Bus rules:
  - Slave has no waitrequest; every strobe is exactly one cycle.
  - m_read and m_write are never high together.
  - At least one idle cycle (both strobes low) separates consecutive accesses.
  - m_address/m_writedata are valid only while a strobe is high; otherwise 0.
- Control word written to address 0: bit0 = reset, bit1 = enable, bit2 = freeze, other bits 0.
- FSM states and transitions:
  - IDLE: start=1 → latch run_len, busy=1, go to WR_RST. start while busy is ignored.
  - WR_RST: write addr 0, data 0x1, one cycle → GAP1.
  - GAP1: idle one cycle → WR_EN.
  - WR_EN: write addr 0, data 0x2 → RUN; load run counter with latched run_len.
  - RUN: decrement each cycle; leave when counter = 0, i.e. exactly run_len cycles in RUN. run_len=0 → zero cycles in RUN, WR_FRZ follows WR_EN after the mandatory 1 idle cycle.
  - WR_FRZ: write addr 0, data 0x6 (enable|freeze) → GAP2.
  - GAP2: idle one cycle → RD_O1.
  - RD_O1 → WAIT_O1:
    - RD_O1: read addr 2 for one cycle.
    - WAIT_O1: count READ_LATENCY cycles; capture m_readdata into data_ctr on the edge ending the READ_LATENCY-th cycle after the strobe cycle.
  - RD_O2 → WAIT_O2: same for addr 3 → event_ctr.
  - RD_O3 → WAIT_O3: same for addr 4 → sys_version.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Outputs data_ctr/event_ctr/sys_version hold their values until overwritten by the next sequence's capture or by reset; they are not cleared at start.
- Timing: start accepted at edge T → first write strobe in cycle T+1.
- Total length from WR_RST to DONE:
  - fixed overhead = WR_RST + GAP1 + WR_EN + the mandatory idle between WR_EN and WR_FRZ + WR_FRZ + GAP2 + 3 × (1 + READ_LATENCY) + DONE;
  - total = fixed overhead + run_len cycles.
- run counter is WIDTH bits, no wrap: run_len = 2^WIDTH−1 runs full length.
- start and DONE in same cycle: start ignored (busy still considered high that cycle); a new start is accepted the cycle after DONE.

Test Plan:
- Reset, idle: hold reset=0 for 3 cycles, release → all outputs 0; no strobe for 20 cycles without start.
- Basic run: run_len=10, slave model returns 0x64/0x3/0x8 → three writes 0x1, 0x2, 0x6 to addr 0 in order; exactly 10 RUN cycles between the 0x2 and 0x6 strobes; data_ctr=0x64, event_ctr=0x3, sys_version=0x8; done single pulse.
- Zero length: run_len=0 → exactly one idle cycle between the 0x2 and 0x6 writes; results still captured correctly.
- Latency: READ_LATENCY=3 with a 3-cycle slave model → captures match; a slave presenting wrong data at latency 1 is not sampled.
- Busy ignore: pulse start again mid-RUN with run_len changed to 5 → original length kept; one done only.
- Mid-run reset: assert reset during RUN → strobes low in the same cycle, outputs 0; new start after release runs a clean full sequence.

Source files
------------

// File: rtl/avalon_tb_sequencer.sv
// Avalon-MM master that runs one full measurement on the testbench CSR slave:
// reset, enable for run_len cycles, freeze, then read back three result registers.
module avalon_tb_sequencer #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] run_len,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_ctr,
   output logic [WIDTH-1:0] event_ctr,
   output logic [WIDTH-1:0] sys_version,
   output logic [3:0]       m_address,
   output logic             m_read,
   output logic             m_write,
   output logic [WIDTH-1:0] m_writedata,
   input  logic [WIDTH-1:0] m_readdata
);

   typedef enum logic [3:0] {
      StIdle, StWrRst, StGap1, StWrEn, StRun, StWrFrz, StGap2, StRd, StWait, StDone
   } state_t;

   localparam logic [WIDTH-1:0] CtlRst = WIDTH'(3'b001);
   localparam logic [WIDTH-1:0] CtlEn  = WIDTH'(3'b010);
   localparam logic [WIDTH-1:0] CtlFrz = WIDTH'(3'b110);
   localparam logic [1:0]       LatInit = 2'(READ_LATENCY - 1);

   state_t           state_q;
   logic [WIDTH-1:0] len_q;
   logic [WIDTH-1:0] cnt_q;
   logic [1:0]       lat_q;
   logic [1:0]       idx_q;

   // Strobes, address and write data default low every cycle so each access lasts one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         len_q       <= '0;
         cnt_q       <= '0;
         lat_q       <= '0;
         idx_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         data_ctr    <= '0;
         event_ctr   <= '0;
         sys_version <= '0;
         m_address   <= '0;
         m_read      <= 1'b0;
         m_write     <= 1'b0;
         m_writedata <= '0;
      end else begin
         m_read      <= 1'b0;
         m_write     <= 1'b0;
         m_address   <= '0;
         m_writedata <= '0;
         done        <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  len_q       <= run_len;
                  busy        <= 1'b1;
                  m_write     <= 1'b1;
                  m_writedata <= CtlRst;
                  state_q     <= StWrRst;
               end
            end
            StWrRst: state_q <= StGap1;
            StGap1: begin
               m_write     <= 1'b1;
               m_writedata <= CtlEn;
               state_q     <= StWrEn;
            end
            StWrEn: begin
               cnt_q   <= len_q;
               state_q <= StRun;
            end
            // The first RUN cycle doubles as the mandatory idle after the enable write.
            StRun: begin
               if (cnt_q == '0) begin
                  m_write     <= 1'b1;
                  m_writedata <= CtlFrz;
                  state_q     <= StWrFrz;
               end else begin
                  cnt_q <= cnt_q - WIDTH'(1);
               end
            end
            StWrFrz: state_q <= StGap2;
            StGap2: begin
               m_read    <= 1'b1;
               m_address <= 4'd2;
               idx_q     <= 2'd0;
               state_q   <= StRd;
            end
            StRd: begin
               lat_q   <= LatInit;
               state_q <= StWait;
            end
            StWait: begin
               if (lat_q == 2'd0) begin
                  case (idx_q)
                     2'd0:    data_ctr    <= m_readdata;
                     2'd1:    event_ctr   <= m_readdata;
                     default: sys_version <= m_readdata;
                  endcase
                  if (idx_q == 2'd2) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     m_read    <= 1'b1;
                     m_address <= 4'd3 + {2'b00, idx_q};
                     idx_q     <= idx_q + 2'd1;
                     state_q   <= StRd;
                  end
               end else begin
                  lat_q <= lat_q - 2'd1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
